// File: rtl/npc_btb_gen_if.sv
// Purpose: redirect/fetch bundle between the execute stage, fetch and the
//          next-PC generator.
// Signals:
//   stall          back-pressure from fetch/decode, holds the PC
//   redirect_*     execute-stage control-flow correction (valid, op, pc)
//   immout/aluout  operands for the redirect target computation
//   pc             registered fetch PC
//   pred_taken     combinational BTB hit for the current pc
//   flush/misalign registered one-cycle pulses after a redirect or trap
interface npc_btb_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [2:0]      redirect_op;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] immout;
  logic [XLEN-1:0] aluout;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic            flush;
  logic            misalign;

  // Execute/fetch side: drives corrections, consumes the PC.
  modport master (
    output stall, redirect_valid, redirect_op, redirect_pc, immout, aluout,
    input  pc, pred_taken, flush, misalign
  );

  // Next-PC generator side.
  modport slave (
    input  stall, redirect_valid, redirect_op, redirect_pc, immout, aluout,
    output pc, pred_taken, flush, misalign
  );
endinterface

// File: rtl/npc_btb_gen.sv
// Purpose: fetch PC register with execute-stage redirects, misaligned-target
//          trap and a direct-mapped BTB for taken-flow prediction.
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   npc_btb_gen_if.slave (stall, redirect inputs, pc/pred_taken/
//         flush/misalign outputs)
module npc_btb_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int unsigned     BTB_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  npc_btb_gen_if.slave   bus
);

  localparam int unsigned IDX   = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JAL    = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  logic [XLEN-1:0]      r_pc;
  logic                 r_flush;
  logic                 r_misalign;
  logic [BTB_DEPTH-1:0] r_btb_valid;
  logic [TAG_W-1:0]     r_btb_tag [BTB_DEPTH];
  logic [XLEN-1:0]      r_btb_tgt [BTB_DEPTH];

  logic [IDX-1:0]   w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_hit;
  logic [XLEN-1:0]  w_pred_tgt;

  logic [IDX-1:0]   w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_op_direct;
  logic             w_op_jalr;
  logic [XLEN-1:0]  w_tgt;
  logic             w_bad;
  logic             w_btb_wr;
  logic             w_btb_clr;

  logic [XLEN-1:0]  w_pc_nxt;
  logic             w_flush_nxt;
  logic             w_misalign_nxt;

  // BTB lookup on the current fetch PC.
  assign w_lk_idx   = r_pc[IDX+1:2];
  assign w_lk_tag   = r_pc[XLEN-1:IDX+2];
  assign w_hit      = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_tgt = r_btb_tgt[w_lk_idx];

  // Redirect decode; unknown op codes fall back to PLUS4.
  assign w_rd_idx    = bus.redirect_pc[IDX+1:2];
  assign w_rd_tag    = bus.redirect_pc[XLEN-1:IDX+2];
  assign w_op_direct = (bus.redirect_op == OP_BRANCH) || (bus.redirect_op == OP_JAL);
  assign w_op_jalr   = (bus.redirect_op == OP_JALR);

  // Redirect target.
  always_comb begin
    w_tgt = bus.redirect_pc + XLEN'(4);
    if (w_op_direct) begin
      w_tgt = bus.redirect_pc + bus.immout;
    end else if (w_op_jalr) begin
      w_tgt = bus.aluout & ~XLEN'(1);
    end
  end

  assign w_bad = bus.redirect_valid && w_tgt[1];

  // BTB maintenance: taken direct flow installs, a not-taken fix evicts.
  assign w_btb_wr  = bus.redirect_valid && !w_bad && w_op_direct;
  assign w_btb_clr = bus.redirect_valid && !w_bad && !w_op_direct && !w_op_jalr &&
                     r_btb_valid[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag);

  // Next-PC priority: trap, redirect, stall, prediction, sequential.
  always_comb begin
    w_pc_nxt       = r_pc + XLEN'(4);
    w_flush_nxt    = 1'b0;
    w_misalign_nxt = 1'b0;
    if (w_bad) begin
      w_pc_nxt       = TRAP_VEC;
      w_flush_nxt    = 1'b1;
      w_misalign_nxt = 1'b1;
    end else if (bus.redirect_valid) begin
      w_pc_nxt    = w_tgt;
      w_flush_nxt = 1'b1;
    end else if (bus.stall) begin
      w_pc_nxt = r_pc;
    end else if (w_hit) begin
      w_pc_nxt = w_pred_tgt;
    end
  end

  // PC and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= RESET_PC;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_flush    <= w_flush_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // Valid bits are the only BTB state that needs reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_btb_valid <= '0;
    end else if (w_btb_wr) begin
      r_btb_valid[w_rd_idx] <= 1'b1;
    end else if (w_btb_clr) begin
      r_btb_valid[w_rd_idx] <= 1'b0;
    end
  end

  // Tag/target storage, qualified by the valid bits above.
  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_rd_idx] <= w_rd_tag;
      r_btb_tgt[w_rd_idx] <= w_tgt;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.pred_taken = w_hit;
  assign bus.flush      = r_flush;
  assign bus.misalign   = r_misalign;

endmodule

// File: tb/tb_npc_btb_gen.sv
// Purpose: directed self-checking bench for npc_btb_gen (BTB_DEPTH 8,
//          index pc[4:2], tag pc[31:5]).
module tb_npc_btb_gen;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JAL    = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  npc_btb_gen_if #(.XLEN(32)) bus ();

  npc_btb_gen #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0100), .BTB_DEPTH(8)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rpc,
                       input logic [31:0] imm, input logic [31:0] alu);
    bus.redirect_valid = 1'b1;
    bus.redirect_op    = op;
    bus.redirect_pc    = rpc;
    bus.immout         = imm;
    bus.aluout         = alu;
  endtask

  task automatic idle();
    bus.redirect_valid = 1'b0;
    bus.redirect_op    = OP_PLUS4;
    bus.redirect_pc    = '0;
    bus.immout         = '0;
    bus.aluout         = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    bus.stall = 1'b0;
    idle();
    #2 rstn = 1'b0;
    #2;
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign); end
    checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", bus.pred_taken); end
    step();
    step();
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_hold_pc got=%h exp=%h", bus.pc, 32'h0); end
    #2 rstn = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'h4;
      checks++; if (bus.pc !== exp_pc) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc, exp_pc); end
      checks++; if (bus.pred_taken !== 1'b0 || bus.flush !== 1'b0) begin failures++; $display("FAIL seq_flags[%0d] pred=%b flush=%b exp=0/0", i, bus.pred_taken, bus.flush); end
    end
  endtask

  task automatic test_branch();
    step();
    checks++; if (bus.pc !== 32'h10) begin failures++; $display("FAIL br_pre_pc got=%h exp=%h", bus.pc, 32'h10); end
    drive(OP_BRANCH, 32'h8, 32'h40, 32'h0);
    step();
    idle();
    checks++; if (bus.pc !== 32'h48) begin failures++; $display("FAIL br_tgt_pc got=%h exp=%h", bus.pc, 32'h48); end
    checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL br_flush got=%b exp=1", bus.flush); end
    checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL br_alias_pred got=%b exp=0", bus.pred_taken); end
    step();
    checks++; if (bus.pc !== 32'h4C || bus.flush !== 1'b0) begin failures++; $display("FAIL br_after pc=%h flush=%b exp=0000004c/0", bus.pc, bus.flush); end
    drive(OP_JALR, 32'h4C, 32'h0, 32'h8);
    step();
    idle();
    checks++; if (bus.pc !== 32'h8) begin failures++; $display("FAIL br_revisit_pc got=%h exp=%h", bus.pc, 32'h8); end
    checks++; if (bus.pred_taken !== 1'b1) begin failures++; $display("FAIL br_hit_pred got=%b exp=1", bus.pred_taken); end
    step();
    checks++; if (bus.pc !== 32'h48) begin failures++; $display("FAIL br_pred_pc got=%h exp=%h", bus.pc, 32'h48); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL br_pred_flush got=%b exp=0", bus.flush); end
  endtask

  task automatic test_plus4_clear();
    drive(OP_PLUS4, 32'h8, 32'h0, 32'h0);
    step();
    idle();
    checks++; if (bus.pc !== 32'hC || bus.flush !== 1'b1) begin failures++; $display("FAIL p4_pc pc=%h flush=%b exp=0000000c/1", bus.pc, bus.flush); end
    drive(OP_JALR, 32'hC, 32'h0, 32'h8);
    step();
    idle();
    checks++; if (bus.pc !== 32'h8) begin failures++; $display("FAIL p4_revisit_pc got=%h exp=%h", bus.pc, 32'h8); end
    checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL p4_cleared_pred got=%b exp=0", bus.pred_taken); end
    step();
    checks++; if (bus.pc !== 32'hC) begin failures++; $display("FAIL p4_seq_pc got=%h exp=%h", bus.pc, 32'hC); end
  endtask

  task automatic test_plus4_nomatch();
    drive(OP_BRANCH, 32'h8, 32'h40, 32'h0);
    step();
    // 0x28 shares index 2 with 0x8 but carries a different tag
    drive(OP_PLUS4, 32'h28, 32'h0, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h2C) begin failures++; $display("FAIL p4nm_pc got=%h exp=%h", bus.pc, 32'h2C); end
    drive(OP_JALR, 32'h2C, 32'h0, 32'h8);
    step();
    idle();
    checks++; if (bus.pred_taken !== 1'b1) begin failures++; $display("FAIL p4nm_kept_pred got=%b exp=1", bus.pred_taken); end
  endtask

  task automatic test_jalr_trap();
    bus.stall = 1'b1;
    drive(OP_JALR, 32'h48, 32'h0, 32'h0000_0203);
    step();
    checks++; if (bus.pc !== 32'h100) begin failures++; $display("FAIL jalr_trap_pc got=%h exp=%h", bus.pc, 32'h100); end
    checks++; if (bus.misalign !== 1'b1 || bus.flush !== 1'b1) begin failures++; $display("FAIL jalr_trap_flags mis=%b flush=%b exp=1/1", bus.misalign, bus.flush); end
    drive(OP_JALR, 32'h100, 32'h0, 32'h0000_0205);
    step();
    idle();
    checks++; if (bus.pc !== 32'h204) begin failures++; $display("FAIL jalr_pc got=%h exp=%h", bus.pc, 32'h204); end
    checks++; if (bus.misalign !== 1'b0 || bus.flush !== 1'b1) begin failures++; $display("FAIL jalr_flags mis=%b flush=%b exp=0/1", bus.misalign, bus.flush); end
    checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL jalr_nowrite_pred got=%b exp=0", bus.pred_taken); end
    step();
    checks++; if (bus.pc !== 32'h204 || bus.flush !== 1'b0 || bus.misalign !== 1'b0) begin failures++; $display("FAIL jalr_stall pc=%h flush=%b mis=%b exp=00000204/0/0", bus.pc, bus.flush, bus.misalign); end
    bus.stall = 1'b0;
  endtask

  task automatic test_misalign_branch();
    drive(OP_BRANCH, 32'h10, 32'h2, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h100 || bus.misalign !== 1'b1) begin failures++; $display("FAIL brmis pc=%h mis=%b exp=00000100/1", bus.pc, bus.misalign); end
    drive(OP_JALR, 32'h100, 32'h0, 32'h10);
    step();
    idle();
    checks++; if (bus.pc !== 32'h10 || bus.misalign !== 1'b0) begin failures++; $display("FAIL brmis_revisit pc=%h mis=%b exp=00000010/0", bus.pc, bus.misalign); end
    checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL brmis_nowrite_pred got=%b exp=0", bus.pred_taken); end
  endtask

  task automatic test_stall();
    drive(OP_JALR, 32'h10, 32'h0, 32'h20);
    step();
    idle();
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.pc !== 32'h20 || bus.flush !== 1'b0) begin failures++; $display("FAIL stall[%0d] pc=%h flush=%b exp=00000020/0", i, bus.pc, bus.flush); end
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.pc !== 32'h24) begin failures++; $display("FAIL stall_release got=%h exp=%h", bus.pc, 32'h24); end
  endtask

  task automatic test_wrap();
    drive(OP_JALR, 32'h24, 32'h0, 32'hFFFF_FFFC);
    step();
    idle();
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=%h", bus.pc, 32'hFFFF_FFFC); end
    step();
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, 32'h0); end
  endtask

  task automatic test_back_to_back();
    drive(OP_BRANCH, 32'h40, 32'h20, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h60) begin failures++; $display("FAIL b2b_first got=%h exp=%h", bus.pc, 32'h60); end
    // same index 0, new tag: replaces the entry just written
    drive(OP_JAL, 32'h60, 32'hFFFF_FFE0, 32'h0);
    step();
    idle();
    checks++; if (bus.pc !== 32'h40 || bus.flush !== 1'b1) begin failures++; $display("FAIL b2b_second pc=%h flush=%b exp=00000040/1", bus.pc, bus.flush); end
    checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL b2b_overwrite_pred got=%b exp=0", bus.pred_taken); end
    step();
    checks++; if (bus.pc !== 32'h44) begin failures++; $display("FAIL b2b_seq got=%h exp=%h", bus.pc, 32'h44); end
  endtask

  task automatic test_jal_reset();
    drive(OP_JAL, 32'h30, 32'h100, 32'h0);
    step();
    drive(OP_JALR, 32'h130, 32'h0, 32'h30);
    step();
    idle();
    checks++; if (bus.pc !== 32'h30 || bus.pred_taken !== 1'b1) begin failures++; $display("FAIL jal_hit pc=%h pred=%b exp=00000030/1", bus.pc, bus.pred_taken); end
    drive(OP_JAL, 32'h30, 32'h100, 32'h0);
    step();
    checks++; if (bus.pc !== 32'h130 || bus.flush !== 1'b1) begin failures++; $display("FAIL jal_redir pc=%h flush=%b exp=00000130/1", bus.pc, bus.flush); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.pc !== 32'h0 || bus.flush !== 1'b0) begin failures++; $display("FAIL async_rst pc=%h flush=%b exp=00000000/0", bus.pc, bus.flush); end
    idle();
    #1 rstn = 1'b1;
    step();
    checks++; if (bus.pc !== 32'h4) begin failures++; $display("FAIL post_rst_pc got=%h exp=%h", bus.pc, 32'h4); end
    drive(OP_JALR, 32'h4, 32'h0, 32'h30);
    step();
    idle();
    checks++; if (bus.pc !== 32'h30 || bus.pred_taken !== 1'b0) begin failures++; $display("FAIL post_rst_pred pc=%h pred=%b exp=00000030/0", bus.pc, bus.pred_taken); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_plus4_clear();
    test_plus4_nomatch();
    test_jalr_trap();
    test_misalign_branch();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_jal_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
